// File: rtl/mem_ex_pipeline.sv
// MEM/WB pipeline register for the RV32IM 5-stage pipeline.
// Captures the write-back control bits, memory read data, ALU result and
// destination register index on each rising clock edge and presents them to
// the write-back stage for one full cycle. Every output comes straight from a
// flip-flop, so there is no combinational path from inputs to outputs.
module mem_ex_pipeline #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      Write_enable,
    input  logic                      Memory_access,
    input  logic [DATA_WIDTH-1:0]     Memory_Data,
    input  logic [DATA_WIDTH-1:0]     ALU_Output,
    input  logic [REG_ADDR_WIDTH-1:0] Write_Address,
    output logic                      Write_Enable_Out,
    output logic                      Memory_access_Out,
    output logic [DATA_WIDTH-1:0]     Memory_Data_Out,
    output logic [DATA_WIDTH-1:0]     ALU_Output_Out,
    output logic [REG_ADDR_WIDTH-1:0] Write_Address_out
);

    logic                      writeEnable_q,   writeEnable_d;
    logic                      memAccess_q,     memAccess_d;
    logic [DATA_WIDTH-1:0]     memData_q,       memData_d;
    logic [DATA_WIDTH-1:0]     aluResult_q,     aluResult_d;
    logic [REG_ADDR_WIDTH-1:0] writeAddress_q,  writeAddress_d;

    // Next state is simply the MEM-stage values: the stage never stalls or
    // flushes, and x0 suppression is left to the register file.
    always_comb begin
        writeEnable_d  = Write_enable;
        memAccess_d    = Memory_access;
        memData_d      = Memory_Data;
        aluResult_d    = ALU_Output;
        writeAddress_d = Write_Address;
    end

    // Stage registers; the active-low reset clears them immediately and
    // overrides a coincident clock edge.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            writeEnable_q  <= 1'b0;
            memAccess_q    <= 1'b0;
            memData_q      <= '0;
            aluResult_q    <= '0;
            writeAddress_q <= '0;
        end else begin
            writeEnable_q  <= writeEnable_d;
            memAccess_q    <= memAccess_d;
            memData_q      <= memData_d;
            aluResult_q    <= aluResult_d;
            writeAddress_q <= writeAddress_d;
        end
    end

    assign Write_Enable_Out  = writeEnable_q;
    assign Memory_access_Out = memAccess_q;
    assign Memory_Data_Out   = memData_q;
    assign ALU_Output_Out    = aluResult_q;
    assign Write_Address_out = writeAddress_q;

endmodule

// File: tb/tb_mem_ex_pipeline.sv
// Self-checking bench for the MEM/WB pipeline register.
// The reference model treats the stage as "outputs = whatever bundle was on
// the inputs at the last rising edge while out of reset, else all zero".
module tb_mem_ex_pipeline;

    typedef struct packed {
        logic        we;
        logic        ma;
        logic [31:0] md;
        logic [31:0] ao;
        logic [4:0]  wa;
    } vec_t;

    logic        CLK;
    logic        Reset;
    logic        Write_enable;
    logic        Memory_access;
    logic [31:0] Memory_Data;
    logic [31:0] ALU_Output;
    logic [4:0]  Write_Address;
    logic        Write_Enable_Out;
    logic        Memory_access_Out;
    logic [31:0] Memory_Data_Out;
    logic [31:0] ALU_Output_Out;
    logic [4:0]  Write_Address_out;

    int   testsRun    = 0;
    int   testsFailed = 0;
    vec_t expected;
    vec_t applied;

    mem_ex_pipeline #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .CLK              (CLK),
        .Reset            (Reset),
        .Write_enable     (Write_enable),
        .Memory_access    (Memory_access),
        .Memory_Data      (Memory_Data),
        .ALU_Output       (ALU_Output),
        .Write_Address    (Write_Address),
        .Write_Enable_Out (Write_Enable_Out),
        .Memory_access_Out(Memory_access_Out),
        .Memory_Data_Out  (Memory_Data_Out),
        .ALU_Output_Out   (ALU_Output_Out),
        .Write_Address_out(Write_Address_out)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t observed();
        return {Write_Enable_Out, Memory_access_Out, Memory_Data_Out,
                ALU_Output_Out, Write_Address_out};
    endfunction

    function automatic vec_t randVec();
        vec_t v;
        v.we = 1'($urandom_range(0, 1));
        v.ma = 1'($urandom_range(0, 1));
        v.md = $urandom;
        v.ao = $urandom;
        v.wa = 5'($urandom_range(0, 31));
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        applied       = v;
        Write_enable  = v.we;
        Memory_access = v.ma;
        Memory_Data   = v.md;
        ALU_Output    = v.ao;
        Write_Address = v.wa;
    endtask

    // Advance to 1 ns after the next rising edge and update the model.
    task automatic tick();
        @(posedge CLK);
        if (Reset) expected = applied;
        else       expected = '0;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        applyStimulus('0);
        expected = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if (observed() !== 71'd0) begin
                testsFailed++;
                $display("[TB] FAIL power_up_reset edge %0d: got %h want 0", i, observed());
            end
        end
    endtask

    task automatic test_release_capture();
        vec_t first;
        vec_t second;
        first  = {1'b1, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'b10101};
        second = {1'b0, 1'b0, 32'h12345678, 32'h87654321, 5'b11111};
        Reset = 1'b1;
        applyStimulus(first);
        #2;
        testsRun++;
        if (observed() !== 71'd0) begin
            testsFailed++;
            $display("[TB] FAIL release_no_capture: got %h want 0", observed());
        end
        tick();
        testsRun++;
        if (observed() !== first) begin
            testsFailed++;
            $display("[TB] FAIL first_capture: got %h want %h", observed(), first);
        end
        applyStimulus(randVec());
        #2;
        applyStimulus(randVec());
        #1;
        testsRun++;
        if (observed() !== first) begin
            testsFailed++;
            $display("[TB] FAIL glitch_hidden: got %h want %h", observed(), first);
        end
        applyStimulus(second);
        tick();
        testsRun++;
        if (observed() !== second) begin
            testsFailed++;
            $display("[TB] FAIL second_capture: got %h want %h", observed(), second);
        end
    endtask

    task automatic test_mid_cycle_reset();
        vec_t held;
        held = {1'b0, 1'b0, 32'h12345678, 32'h87654321, 5'b11111};
        #2;
        Reset = 1'b0;
        #1;
        testsRun++;
        if (observed() !== 71'd0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_immediate: got %h want 0", observed());
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            testsRun++;
            if (observed() !== 71'd0) begin
                testsFailed++;
                $display("[TB] FAIL reset_hold edge %0d: got %h want 0", i, observed());
            end
        end
        #2;
        Reset = 1'b1;
        #1;
        testsRun++;
        if (observed() !== 71'd0) begin
            testsFailed++;
            $display("[TB] FAIL post_release_zero: got %h want 0", observed());
        end
        tick();
        testsRun++;
        if (observed() !== held) begin
            testsFailed++;
            $display("[TB] FAIL post_release_load: got %h want %h", observed(), held);
        end
    endtask

    task automatic test_back_to_back();
        vec_t pending[$];
        vec_t want;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(randVec());
            pending.push_back(applied);
            tick();
            want = pending.pop_front();
            testsRun++;
            if (observed() !== want) begin
                testsFailed++;
                $display("[TB] FAIL back_to_back[%0d]: got %h want %h", i, observed(), want);
            end
        end
    endtask

    // Random stream with occasional mid-cycle reset pulses.
    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(randVec());
            if ($urandom_range(0, 7) == 0) begin
                #1;
                Reset = 1'b0;
                expected = '0;
                #1;
                testsRun++;
                if (observed() !== expected) begin
                    testsFailed++;
                    $display("[TB] FAIL random_reset[%0d]: got %h want 0", i, observed());
                end
                if ($urandom_range(0, 1) == 0) Reset = 1'b1;
            end else if (!Reset) begin
                Reset = 1'b1;
            end
            tick();
            testsRun++;
            if (observed() !== expected) begin
                testsFailed++;
                $display("[TB] FAIL random[%0d]: got %h want %h", i, observed(), expected);
            end
        end
    endtask

    initial begin
        test_reset();
        test_release_capture();
        test_mid_cycle_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_ex_pipeline.md
Name: mem_ex_pipeline

Overview:
- MEM/WB pipeline register of the RV32IM 5-stage pipeline, between the memory-access stage and the write-back stage.
- Captures the write-back control bits, the memory read data, the ALU result and the destination register address on each rising clock edge.
- Presents the captured values to write-back for one full cycle.
- Pure register stage: no combinational path from inputs to outputs.

Parameters:
- DATA_WIDTH, 32, width of Memory_Data / ALU_Output and their registered copies.
- REG_ADDR_WIDTH, 5, width of destination register address (32-entry register file).

Ports:
- CLK  input  1  pipeline clock, rising-edge active.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Write_enable  input  1  register-file write enable from MEM stage.
- Memory_access  input  1  write-back mux select from MEM stage (1 = take memory data, 0 = take ALU result).
- Memory_Data  input  DATA_WIDTH  data read from data memory.
- ALU_Output  input  DATA_WIDTH  ALU result forwarded through MEM stage.
- Write_Address  input  REG_ADDR_WIDTH  destination register index (rd).
- Write_Enable_Out  output  1  registered Write_enable.
- Memory_access_Out  output  1  registered Memory_access.
- Memory_Data_Out  output  DATA_WIDTH  registered Memory_Data.
- ALU_Output_Out  output  DATA_WIDTH  registered ALU_Output.
- Write_Address_out  output  REG_ADDR_WIDTH  registered Write_Address.

Behaviour:
- Single clock domain (CLK); all outputs driven directly from flip-flops.
- Reset asynchronous, active-low. When Reset goes 0, all outputs clear immediately, without waiting for a clock edge:
  - Write_Enable_Out=0, Memory_access_Out=0.
  - Memory_Data_Out=0, ALU_Output_Out=0, Write_Address_out=0.
- While Reset=0, outputs stay 0 regardless of CLK or inputs.
- Reset release takes effect at the first rising CLK edge with Reset=1; no capture occurs on the release itself.
- Normal operation (Reset=1), on every rising CLK edge: each output register loads its input, unconditionally. No enable, stall or flush.
- Latency: exactly 1 cycle. A value applied before edge N appears after edge N and holds until edge N+1.
- Input changes between edges have no effect on outputs.
- Reset asserted mid-operation discards the captured state; after release, outputs stay 0 until the next rising edge, which loads the current inputs.
- Reset and a rising edge at the same instant: reset wins, outputs = 0.
- All fields are carried independently and bit-exact. No width conversion, sign extension, or interpretation of Write_Address=0 (x0 suppression is the register file's job).
- Outputs are never X/Z after the first reset.

Test Plan:
- Power-up with Reset=0, inputs all zero, CLK toggling (10 ns period) -> all outputs 0 on every edge.
- Release Reset=1, apply Write_enable=1, Memory_access=1, Memory_Data=A5A5A5A5, ALU_Output=5A5A5A5A, Write_Address=10101.
  -> Outputs unchanged until the next rising edge, then show 1/1/A5A5A5A5/5A5A5A5A/10101.
- Next cycle apply 0/0/12345678/87654321/11111 -> after the following edge, outputs equal those values. Intermediate glitches on the inputs are never visible.
- With outputs holding 12345678/87654321/11111, drive Reset=0 mid-cycle (between edges) -> all outputs go 0 immediately, not at the next edge.
- Hold Reset=0 across two edges with inputs non-zero -> outputs remain 0.
- Release Reset=1 with inputs still 0/0/12345678/87654321/11111 -> outputs stay 0 until the first rising edge, then load those values.
- Back-to-back stream of 4 distinct random vectors, one per cycle -> each vector appears exactly one cycle after it was applied, no drops or duplicates.
